mul_seq: RTL and testbench
==========================

Name: mul_seq

Overview:
Parametrised sequential shift-add multiplier, W×W → 2W, one multiplier bit per clock. Selectable unsigned or two's-complement signed mode. Start/busy/done handshake. Exposes shifting operand registers and the accumulator for 7-segment / LED observation on the board top. The top may drive the clock from a push-switch pulse, so every step must be visible one edge at a time.

Parameters:
W, 4, operand width in bits (W ≥ 2); product width is 2W
CW, $clog2(W+1), step-counter width (derived; not overridden)

Ports:
clk    in   1     system clock (free-running or push-switch pulse, selected in top)
rst    in   1     synchronous, active-high reset
start  in   1     level-sampled start request; accepted only when busy=0
sgn    in   1     0 = unsigned, 1 = two's-complement signed; sampled with start
a      in   W     multiplicand, sampled with start
b      in   W     multiplier, sampled with start
ra     out  2W    multiplicand register, shifted left each step
rb     out  W     multiplier register, shifted right each step
ry     out  2W    product accumulator
cnt    out  CW    steps completed (0..W)
busy   out  1     high in RUN
done   out  1     high in DONE; held until next accepted start or reset

Behaviour:
- States: IDLE, RUN, DONE. Reset (rst=1 at a clk edge) → IDLE; ra, rb, ry, cnt = 0; busy = 0; done = 0. Reset wins over every other input, including mid-RUN, which aborts the operation with no partial result kept.
- IDLE/DONE with start=1 at an edge (load edge):
  - ra ← a zero-extended (sgn=0) or sign-extended (sgn=1) to 2W.
  - rb ← b; ry ← 0; cnt ← 0.
  - Latch sgn internally; state → RUN; done ← 0.
- IDLE/DONE with start=0: all registers hold.
- RUN, each edge (step i = cnt, 0..W-1):
  - If rb[0]=1: ry ← ry + ra, except when step i = W-1 and the latched sgn=1, where ry ← ry − ra. The multiplier MSB has negative weight.
  - All arithmetic is modulo 2^2W.
  - ra ← ra << 1; rb ← rb >> 1 with zero fill; cnt ← cnt + 1.
  - When the step that makes cnt = W completes, state → DONE.
- start during RUN is ignored; a, b, sgn changes during RUN have no effect.
- Latency: the load edge plus W step edges. done and the final ry are visible after edge W+1, counted from the load edge.
- In DONE: ry holds the full 2W-bit product; rb = 0; cnt = W.
- start held high continuously: each DONE lasts exactly one cycle, then an immediate reload occurs (back-to-back operation, W+1 edges per product).
- b = 0: RUN still takes W steps and gives ry = 0. There is no early termination, so latency is fixed.
- Signed boundary: (−2^(W−1)) × (−2^(W−1)) = 2^(2W−2), exact with no overflow. Unsigned maximum (2^W−1)^2 fits in 2W bits.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a width-extension helper function (zero-/sign-extend W → 2W).
- Single module. The add/subtract datapath is one expression, so no sub-module is needed.
- The top keeps its existing wiring style: ld maps to start, and rtsw values map to a and b.

Test Plan:
- W=4, sgn=0, a=4'hF, b=4'hF, start pulse → after 5 edges: done=1, ry=8'hE1, cnt=4, rb=0. busy is high for exactly 4 cycles.
- W=4, sgn=1, a=4'hD (−3), b=4'h5 → ry=8'hF1 (−15). Also a=4'h7, b=4'hF (−1) → ry=8'hF9. Also a=4'h8, b=4'h8 → ry=8'h40.
- W=4, a=4'h9, b=4'h0 → done after 5 edges, ry=0. Per-step trace of ra: 09, 12, 24, 48, 90 (hex).
- Handshake: start reasserted mid-RUN with new a, b → ignored, original product produced. start held high → done pulses one cycle every 5 edges and alternating operands are loaded correctly.
- rst=1 at step 2 of RUN → next edge: IDLE, all outputs 0. Subsequent start yields the correct product. rst asserted simultaneously with start → IDLE.
- W=8: unsigned 8'hFF×8'hFF → 16'hFE01 after 9 edges. Signed 8'h80×8'h80 → 16'h4000.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Provides the state encoding and the W -> 2W operand extension helper.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Extends the low w bits of v to 64 bits, by sign bit (sgn=1) or zeros.
  // Callers take the low 2W bits; supports operand widths up to 32.
  function automatic logic [63:0] ext_w(input logic [31:0] v, input int unsigned w,
                                        input logic sgn);
    logic [63:0] r;
    logic        fill;
    r    = {32'd0, v};
    fill = sgn & v[w-1];
    for (int i = 0; i < 64; i++) begin
      if (i >= int'(w)) r[i] = fill;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_seq.sv
// Shift-add multiplier W x W -> 2W, one multiplier bit per clk; unsigned or signed.
// Latency: load edge + W step edges; start is ignored while busy (no other backpressure).
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            sgn,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic [2*W-1:0]  ra,
  output logic [W-1:0]    rb,
  output logic [2*W-1:0]  ry,
  output logic [CW-1:0]   cnt,
  output logic            busy,
  output logic            done
);

  state_t          state_q, state_d;
  logic [2*W-1:0]  ra_q, ra_d;
  logic [W-1:0]    rb_q, rb_d;
  logic [2*W-1:0]  ry_q, ry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sgn_q, sgn_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [63:0]     a_ext;
  logic            last_step;

  assign last_step = (cnt_q == CW'(W - 1));

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    ry_d    = ry_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    busy_d  = busy_q;
    done_d  = done_q;
    a_ext   = ext_w(32'(a), W, sgn);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          ra_d    = a_ext[2*W-1:0];
          rb_d    = b;
          ry_d    = '0;
          cnt_d   = '0;
          sgn_d   = sgn;
          state_d = S_RUN;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_RUN: begin
        // The multiplier MSB carries negative weight in signed mode.
        if (rb_q[0]) begin
          if (last_step && sgn_q) ry_d = ry_q - ra_q;
          else                    ry_d = ry_q + ra_q;
        end
        ra_d  = ra_q << 1;
        rb_d  = rb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      ry_q    <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      ry_q    <= ry_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ra   = ra_q;
  assign rb   = rb_q;
  assign ry   = ry_q;
  assign cnt  = cnt_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq at W=4 and W=8 with hand-computed products.
module tb_mul_seq;

  logic       clk;
  logic       rst;
  logic       start4, sgn4;
  logic [3:0] a4, b4;
  logic [7:0] ra4, ry4;
  logic [3:0] rb4;
  logic [2:0] cnt4;
  logic       busy4, done4;

  logic        start8, sgn8;
  logic [7:0]  a8, b8;
  logic [15:0] ra8, ry8;
  logic [7:0]  rb8;
  logic [3:0]  cnt8;
  logic        busy8, done8;

  int checks;
  int failures;

  mul_seq #(.W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sgn(sgn4), .a(a4), .b(b4),
    .ra(ra4), .rb(rb4), .ry(ry4), .cnt(cnt4), .busy(busy4), .done(done4)
  );

  mul_seq #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .a(a8), .b(b8),
    .ra(ra8), .rb(rb8), .ry(ry8), .cnt(cnt8), .busy(busy8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load, then W=4 steps; checks busy duration and the final DONE state.
  task automatic run4(input string tag, input logic s, input logic [3:0] av,
                      input logic [3:0] bv, input logic [7:0] exp);
    int nbusy;
    nbusy  = 0;
    sgn4   = s;
    a4     = av;
    b4     = bv;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    if (busy4) nbusy++;
    chk({tag, "_done_lo"}, done4, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy4) nbusy++;
    end
    chk({tag, "_busy_cycles"}, nbusy, 4);
    chk({tag, "_done"}, done4, 1);
    chk({tag, "_ry"}, ry4, exp);
    chk({tag, "_cnt"}, cnt4, 4);
    chk({tag, "_rb"}, rb4, 0);
  endtask

  task automatic run8(input string tag, input logic s, input logic [7:0] av,
                      input logic [7:0] bv, input logic [15:0] exp, input logic [15:0] exp_ra);
    sgn8   = s;
    a8     = av;
    b8     = bv;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk({tag, "_busy_before_last"}, busy8, 1);
    tick();
    chk({tag, "_done"}, done8, 1);
    chk({tag, "_busy"}, busy8, 0);
    chk({tag, "_ry"}, ry8, exp);
    chk({tag, "_cnt"}, cnt8, 8);
    chk({tag, "_rb"}, rb8, 0);
    chk({tag, "_ra"}, ra8, exp_ra);
  endtask

  initial begin
    logic [7:0] ra_trace [5];
    ra_trace = '{8'h09, 8'h12, 8'h24, 8'h48, 8'h90};
    checks   = 0;
    failures = 0;
    rst    = 1'b1;
    start4 = 1'b0; sgn4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    start8 = 1'b0; sgn8 = 1'b0; a8 = 8'h0; b8 = 8'h0;
    tick();
    tick();
    chk("rst_ra", ra4, 0);
    chk("rst_rb", rb4, 0);
    chk("rst_ry", ry4, 0);
    chk("rst_cnt", cnt4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    rst = 1'b0;
    tick();
    chk("idle_hold_busy", busy4, 0);

    run4("u_ff", 1'b0, 4'hF, 4'hF, 8'hE1);
    tick();
    chk("done_held", done4, 1);
    chk("done_held_ry", ry4, 8'hE1);

    run4("s_d5", 1'b1, 4'hD, 4'h5, 8'hF1);
    run4("s_7f", 1'b1, 4'h7, 4'hF, 8'hF9);
    run4("s_88", 1'b1, 4'h8, 4'h8, 8'h40);
    run4("u_b0", 1'b0, 4'h9, 4'h0, 8'h00);

    // Per-step trace of the shifting multiplicand.
    sgn4 = 1'b0; a4 = 4'h9; b4 = 4'h0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("trace_ra0", ra4, ra_trace[0]);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk($sformatf("trace_ra%0d", i), ra4, ra_trace[i]);
    end

    // start with new operands mid-RUN must be ignored.
    sgn4 = 1'b0; a4 = 4'h3; b4 = 4'h5; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    a4 = 4'hF; b4 = 4'hF; sgn4 = 1'b1; start4 = 1'b1;
    tick();
    tick();
    start4 = 1'b0;
    chk("midrun_done", done4, 1);
    chk("midrun_ry", ry4, 8'h0F);

    // start held high: back-to-back products with alternating operands.
    sgn4 = 1'b0; a4 = 4'h2; b4 = 4'h3; start4 = 1'b1;
    tick();
    a4 = 4'h5; b4 = 4'h7;
    for (int i = 0; i < 4; i++) tick();
    chk("b2b_1_done", done4, 1);
    chk("b2b_1_ry", ry4, 8'h06);
    tick();
    chk("b2b_reload_done", done4, 0);
    chk("b2b_reload_busy", busy4, 1);
    a4 = 4'h2; b4 = 4'h3;
    for (int i = 0; i < 4; i++) tick();
    chk("b2b_2_done", done4, 1);
    chk("b2b_2_ry", ry4, 8'h23);
    tick();
    start4 = 1'b0;
    chk("b2b_pulse_len", done4, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("b2b_3_done", done4, 1);
    chk("b2b_3_ry", ry4, 8'h06);

    // Reset at step 2 aborts the operation.
    sgn4 = 1'b0; a4 = 4'h7; b4 = 4'h6; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    chk("abort_pre_cnt", cnt4, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ra", ra4, 0);
    chk("abort_rb", rb4, 0);
    chk("abort_ry", ry4, 0);
    chk("abort_cnt", cnt4, 0);
    chk("abort_busy", busy4, 0);
    chk("abort_done", done4, 0);
    run4("after_abort", 1'b0, 4'h7, 4'h6, 8'h2A);

    // Reset wins over a simultaneous start.
    rst = 1'b1; start4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
    tick();
    rst = 1'b0; start4 = 1'b0;
    chk("rst_start_busy", busy4, 0);
    chk("rst_start_ra", ra4, 0);
    chk("rst_start_done", done4, 0);
    tick();
    chk("rst_start_idle", busy4, 0);

    run8("w8_u", 1'b0, 8'hFF, 8'hFF, 16'hFE01, 16'hFF00);
    run8("w8_s", 1'b1, 8'h80, 8'h80, 16'h4000, 16'h8000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
